rca16_share_arb: RTL and testbench

RCA16_SHARE_ARB -- requirements
Module: rca16_share_arb

---
 rtl/rca16_arb_pkg.sv | 12 +
 rtl/h_s_rca16.sv | 22 ++
 rtl/rca16_share_arb.sv | 106 ++++++++++
 tb/tb_rca16_share_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rca16_arb_pkg.sv
// Shared widths and output-slot state for the shared-adder arbiter.
package rca16_arb_pkg;

    localparam int unsigned AddW = 16;
    localparam int unsigned SumW = 17;

    typedef enum logic {
        Empty,
        Full
    } slot_state_e;

endpackage

// File: rtl/h_s_rca16.sv
// 16-bit signed ripple-carry adder; 17-bit result is the exact sign-extended sum.
module h_s_rca16
    import rca16_arb_pkg::*;
(
    input  logic [AddW-1:0] a,
    input  logic [AddW-1:0] b,
    output logic [SumW-1:0] sum
);

    always_comb begin : ripple
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int unsigned i = 0; i < AddW; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        // Top bit equals the sum bit of the sign-extended operands.
        sum[AddW] = a[AddW-1] ^ b[AddW-1] ^ c;
    end

endmodule

// File: rtl/rca16_share_arb.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters,
// with a single-entry output slot and a transfer counter.
module rca16_share_arb
    import rca16_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AddW-1:0] req_a,
    input  logic [NREQ*AddW-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SumW-1:0]      rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          grant_cnt
);

    slot_state_e     slot_q, slot_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [SumW-1:0] sum_q, sum_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [IDW-1:0]  gnt_idx;
    logic            gnt_found;
    logic            slot_free;
    logic            xfer;
    logic [AddW-1:0] op_a, op_b;
    logic [SumW-1:0] add_sum;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin : arbiter
        logic [IDW-1:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        slot_free = (slot_q == Empty) || rsp_ready;
        xfer      = !rst && slot_free && gnt_found;
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a = req_a[32'(gnt_idx) * AddW +: AddW];
    assign op_b = req_b[32'(gnt_idx) * AddW +: AddW];

    h_s_rca16 u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        id_d   = id_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            slot_d = Full;
            sum_d  = add_sum;
            id_d   = gnt_idx;
            ptr_d  = IDW'((32'(gnt_idx) + 1) % NREQ);
            cnt_d  = cnt_q + 16'd1;
        end else if (rsp_ready) begin
            slot_d = Empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= Empty;
            ptr_q  <= '0;
            id_q   <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rsp_valid = (slot_q == Full);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rca16_share_arb.sv
// Randomised and directed bench for rca16_share_arb against a behavioural model.
module tb_rca16_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [16:0]       rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       grant_cnt;

    always #5 clk = ~clk;

    rca16_share_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .grant_cnt (grant_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the pending result, the round-robin start point, transfer count.
    bit          m_full;
    bit          m_known;
    logic [16:0] m_sum;
    int          m_id;
    int          m_ptr;
    int          m_cnt;
    logic [15:0] op_a [NREQ];
    logic [15:0] op_b [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic r);
        int              g;
        int              s;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
        #1;
        g = -1;
        if (!r && (!m_full || rdy)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));

        if (r) begin
            m_full  = 0;
            m_known = 1;
            m_sum   = '0;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (g >= 0) begin
            s       = int'($signed(op_a[g])) + int'($signed(op_b[g]));
            m_full  = 1;
            m_known = 1;
            m_sum   = 17'(s);
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (rdy) begin
            m_full  = 0;
            m_known = 0;
        end

        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        if (m_known) begin
            check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rand_ops();

        // Reset with requests pending: none may be accepted.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_cnt", 32'(grant_cnt), 32'd0);

        // Positive boundary sum.
        op_a[0] = 16'h7FFF;
        op_b[0] = 16'h0001;
        step(4'b0001, 1'b0, 1'b0);
        check("pos_sum", 32'(rsp_sum), 32'h08000);
        check("pos_id", 32'(rsp_id), 32'd0);
        check("pos_cnt", 32'(grant_cnt), 32'd1);

        // Full round-robin rotation at one result per cycle, most negative sum.
        step(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 16'h8000;
            op_b[i] = 16'h8000;
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            check("rr_id", 32'(rsp_id), 32'(i % NREQ));
            check("neg_sum", 32'(rsp_sum), 32'h10000);
        end

        // Back-pressure: slot held, no grant; drain releases requester 1 the same cycle.
        rand_ops();
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            check("hold_sum", 32'(rsp_sum), 32'h10000);
            check("hold_id", 32'(rsp_id), 32'd0);
        end
        step(4'b0010, 1'b1, 1'b0);
        check("drain_gnt", 32'(rsp_id), 32'd1);

        // Pointer wrap: ptr=2 with requesters 0 and 1 pending.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        check("wrap_gnt0", 32'(rsp_id), 32'd0);
        step(4'b0011, 1'b1, 1'b0);
        check("wrap_gnt1", 32'(rsp_id), 32'd1);

        // Pending result discarded by reset; arbitration restarts at 0.
        step(4'b0000, 1'b1, 1'b1);
        op_a[0] = 16'h0002;
        op_b[0] = 16'h0003;
        step(4'b0001, 1'b0, 1'b0);
        check("pend_sum", 32'(rsp_sum), 32'h00005);
        step(4'b0001, 1'b0, 1'b1);
        check("rst_drop_valid", 32'(rsp_valid), 32'd0);
        check("rst_drop_cnt", 32'(grant_cnt), 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("rst_restart", 32'(rsp_id), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_ops();
            step(4'($urandom), 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        // Counter wrap after 65536 transfers.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 65536; i++) begin
            rand_ops();
            step(4'b1111, 1'b1, 1'b0);
        end
        check("cnt_wrap", 32'(grant_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
